// File: rtl/vc_pkg.sv
// Shared encodings and defaults for the VC push controller.
package vc_pkg;
  localparam int DATA_WIDTH   = 6;
  localparam int VC_SEL_BIT   = 5;
  localparam int TH_WIDTH     = 4;
  // Almost-full thresholds must leave this many free entries for words in flight.
  localparam int MIN_AF_SLACK = 2;

  typedef enum logic [2:0] {
    ST_RESET  = 3'd0,
    ST_INIT   = 3'd1,
    ST_IDLE   = 3'd2,
    ST_ACTIVE = 3'd3,
    ST_ERROR  = 3'd4
  } state_e;
endpackage

// File: rtl/vc_route_stage.sv
// Registered demux of the popped Main word onto VC0/VC1, with overflow detect
// and combinational suppression of a push into a full VC.
module vc_route_stage #(
  parameter int DATA_WIDTH = vc_pkg::DATA_WIDTH,
  parameter int VC_SEL_BIT = vc_pkg::VC_SEL_BIT
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  rd_pend,
  input  logic                  kill,
  input  logic [DATA_WIDTH-1:0] main_data,
  input  logic                  vc0_full,
  input  logic                  vc1_full,
  output logic                  vc0_wr,
  output logic                  vc1_wr,
  output logic [DATA_WIDTH-1:0] vc_data,
  output logic                  overflow
);
  logic                  wr0_q, wr0_d;
  logic                  wr1_q, wr1_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;

  always_comb begin
    wr0_d  = 1'b0;
    wr1_d  = 1'b0;
    data_d = data_q;
    if (rd_pend && !kill) begin
      data_d = main_data;
      wr1_d  = main_data[VC_SEL_BIT];
      wr0_d  = !main_data[VC_SEL_BIT];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr0_q  <= 1'b0;
      wr1_q  <= 1'b0;
      data_q <= '0;
    end else begin
      wr0_q  <= wr0_d;
      wr1_q  <= wr1_d;
      data_q <= data_d;
    end
  end

  assign overflow = (wr0_q && vc0_full) || (wr1_q && vc1_full);
  assign vc0_wr   = wr0_q && !vc0_full;
  assign vc1_wr   = wr1_q && !vc1_full;
  assign vc_data  = data_q;
endmodule

// File: rtl/vc_push_ctrl.sv
// Write-side controller: pops Main, routes each word to VC0/VC1 by its select
// bit, throttles on almost-full, latches thresholds in INIT, sticky ERROR.
module vc_push_ctrl #(
  parameter int DATA_WIDTH = vc_pkg::DATA_WIDTH,
  parameter int VC_SEL_BIT = vc_pkg::VC_SEL_BIT,
  parameter int TH_WIDTH   = vc_pkg::TH_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  init,
  input  logic [TH_WIDTH-1:0]   umbral_vc0_in,
  input  logic [TH_WIDTH-1:0]   umbral_vc1_in,
  input  logic                  Main_empty,
  input  logic [DATA_WIDTH-1:0] Main_data,
  input  logic                  VC0_almost_full,
  input  logic                  VC1_almost_full,
  input  logic                  VC0_full,
  input  logic                  VC1_full,
  output logic                  Main_rd,
  output logic                  VC0_wr,
  output logic                  VC1_wr,
  output logic [DATA_WIDTH-1:0] VC_data,
  output logic [TH_WIDTH-1:0]   umbral_vc0,
  output logic [TH_WIDTH-1:0]   umbral_vc1,
  output logic [2:0]            state,
  output logic                  idle,
  output logic                  error
);
  import vc_pkg::*;

  state_e              state_q, state_d;
  logic                rd_pend_q, rd_pend_d;
  logic [TH_WIDTH-1:0] th0_q, th0_d;
  logic [TH_WIDTH-1:0] th1_q, th1_d;
  logic                overflow;
  logic                push;
  logic                pipe_busy;

  // Destination is unknown until the word is read, so both VCs gate the pop.
  assign Main_rd = (state_q == ST_ACTIVE) && !Main_empty && !VC0_almost_full &&
                   !VC1_almost_full && !init;

  vc_route_stage #(
    .DATA_WIDTH (DATA_WIDTH),
    .VC_SEL_BIT (VC_SEL_BIT)
  ) u_route (
    .clk       (clk),
    .reset     (reset),
    .rd_pend   (rd_pend_q),
    .kill      ((state_q == ST_ERROR) || overflow),
    .main_data (Main_data),
    .vc0_full  (VC0_full),
    .vc1_full  (VC1_full),
    .vc0_wr    (VC0_wr),
    .vc1_wr    (VC1_wr),
    .vc_data   (VC_data),
    .overflow  (overflow)
  );

  assign push      = VC0_wr || VC1_wr;
  assign pipe_busy = rd_pend_q || push;

  always_comb begin
    state_d   = state_q;
    rd_pend_d = Main_rd;
    th0_d     = th0_q;
    th1_d     = th1_q;
    case (state_q)
      ST_RESET: state_d = ST_INIT;
      ST_INIT: begin
        th0_d = umbral_vc0_in;
        th1_d = umbral_vc1_in;
        if (!init) state_d = ST_IDLE;
      end
      ST_IDLE: begin
        if (init)             state_d = ST_INIT;
        else if (!Main_empty) state_d = ST_ACTIVE;
      end
      ST_ACTIVE: begin
        // init waits for in-flight words to drain before reloading thresholds
        if (init) begin
          if (!pipe_busy) state_d = ST_INIT;
        end else if (Main_empty && !pipe_busy) begin
          state_d = ST_IDLE;
        end
      end
      ST_ERROR: state_d = ST_ERROR;
      default:  state_d = ST_ERROR;
    endcase
    if (overflow) state_d = ST_ERROR;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_RESET;
      rd_pend_q <= 1'b0;
      th0_q     <= '0;
      th1_q     <= '0;
    end else begin
      state_q   <= state_d;
      rd_pend_q <= rd_pend_d;
      th0_q     <= th0_d;
      th1_q     <= th1_d;
    end
  end

  assign umbral_vc0 = th0_q;
  assign umbral_vc1 = th1_q;
  assign state      = state_q;
  assign idle       = (state_q == ST_IDLE);
  assign error      = (state_q == ST_ERROR);
endmodule

// File: tb/tb_vc_push_ctrl.sv
// Directed bench for vc_push_ctrl: init/threshold load, routing, throttle,
// init with words in flight, overflow to ERROR, and reset mid-stream.
module tb_vc_push_ctrl;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       init = 1'b0;
  logic [3:0] umbral_vc0_in = 4'd4;
  logic [3:0] umbral_vc1_in = 4'd6;
  logic       Main_empty = 1'b1;
  logic [5:0] Main_data = '0;
  logic       VC0_almost_full = 1'b0;
  logic       VC1_almost_full = 1'b0;
  logic       VC0_full = 1'b0;
  logic       VC1_full = 1'b0;
  logic       Main_rd, VC0_wr, VC1_wr, idle, error;
  logic [5:0] VC_data;
  logic [3:0] umbral_vc0, umbral_vc1;
  logic [2:0] state;

  int checks = 0;
  int errors = 0;

  vc_push_ctrl dut (
    .clk             (clk),
    .reset           (reset),
    .init            (init),
    .umbral_vc0_in   (umbral_vc0_in),
    .umbral_vc1_in   (umbral_vc1_in),
    .Main_empty      (Main_empty),
    .Main_data       (Main_data),
    .VC0_almost_full (VC0_almost_full),
    .VC1_almost_full (VC1_almost_full),
    .VC0_full        (VC0_full),
    .VC1_full        (VC1_full),
    .Main_rd         (Main_rd),
    .VC0_wr          (VC0_wr),
    .VC1_wr          (VC1_wr),
    .VC_data         (VC_data),
    .umbral_vc0      (umbral_vc0),
    .umbral_vc1      (umbral_vc1),
    .state           (state),
    .idle            (idle),
    .error           (error)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h want=0x%0h", tag, act, exp);
    end
  endtask

  // Apply one cycle of inputs at the falling edge, then settle before checking.
  task automatic nx(input logic emp, input logic [5:0] d, input logic ini,
                    input logic af0, input logic af1, input logic f0, input logic f1);
    @(negedge clk);
    Main_empty      = emp;
    Main_data       = d;
    init            = ini;
    VC0_almost_full = af0;
    VC1_almost_full = af1;
    VC0_full        = f0;
    VC1_full        = f1;
    #1;
  endtask

  initial begin
    // reset state
    #1;
    chk("rst_state", state, 0);
    chk("rst_rd", Main_rd, 0);
    chk("rst_wr0", VC0_wr, 0);
    chk("rst_wr1", VC1_wr, 0);
    chk("rst_data", VC_data, 0);
    chk("rst_th0", umbral_vc0, 0);
    chk("rst_th1", umbral_vc1, 0);
    chk("rst_idle", idle, 0);
    chk("rst_err", error, 0);

    // init sequence: RESET -> INIT -> IDLE with thresholds 4/6
    @(negedge clk); reset = 1'b0; init = 1'b1; #1;
    chk("seq_reset", state, 0);
    nx(1, 6'h00, 1, 0, 0, 0, 0); chk("seq_init1", state, 1);
    nx(1, 6'h00, 1, 0, 0, 0, 0); chk("seq_init2", state, 1); chk("init_rd", Main_rd, 0);
    nx(1, 6'h00, 0, 0, 0, 0, 0); chk("seq_init3", state, 1);
    chk("th0_load", umbral_vc0, 4); chk("th1_load", umbral_vc1, 6);
    nx(1, 6'h00, 0, 0, 0, 0, 0); chk("seq_idle", state, 2); chk("idle_flag", idle, 1);

    // three words 0x25,0x05,0x3F routed VC1,VC0,VC1
    nx(0, 6'h00, 0, 0, 0, 0, 0); chk("r_idle_rd", Main_rd, 0);
    nx(0, 6'h00, 0, 0, 0, 0, 0); chk("r_active", state, 3); chk("r_rd0", Main_rd, 1);
    nx(0, 6'h25, 0, 0, 0, 0, 0); chk("r_rd1", Main_rd, 1); chk("r_nopush", VC0_wr | VC1_wr, 0);
    nx(0, 6'h05, 0, 0, 0, 0, 0); chk("r_rd2", Main_rd, 1);
    chk("r_w1_vc1", VC1_wr, 1); chk("r_w1_vc0", VC0_wr, 0); chk("r_w1_data", VC_data, 6'h25);
    nx(1, 6'h3F, 0, 0, 0, 0, 0); chk("r_rd3", Main_rd, 0);
    chk("r_w2_vc0", VC0_wr, 1); chk("r_w2_vc1", VC1_wr, 0); chk("r_w2_data", VC_data, 6'h05);
    nx(1, 6'h00, 0, 0, 0, 0, 0);
    chk("r_w3_vc1", VC1_wr, 1); chk("r_w3_vc0", VC0_wr, 0); chk("r_w3_data", VC_data, 6'h3F);
    chk("r_busy_state", state, 3);
    nx(1, 6'h00, 0, 0, 0, 0, 0); chk("r_drain_wr", VC0_wr | VC1_wr, 0);
    chk("r_hold_data", VC_data, 6'h3F); chk("r_drain_state", state, 3);
    nx(1, 6'h00, 0, 0, 0, 0, 0); chk("r_back_idle", state, 2);

    // almost-full throttling
    nx(0, 6'h00, 0, 1, 0, 0, 0); chk("af_idle", state, 2);
    nx(0, 6'h00, 0, 1, 0, 0, 0); chk("af_active", state, 3); chk("af0_rd", Main_rd, 0);
    nx(0, 6'h00, 0, 1, 0, 0, 0); chk("af0_rd2", Main_rd, 0); chk("af_nopush", VC0_wr | VC1_wr, 0);
    nx(0, 6'h00, 0, 0, 1, 0, 0); chk("af1_rd", Main_rd, 0);
    nx(0, 6'h00, 0, 0, 0, 0, 0); chk("af_resume", Main_rd, 1);
    nx(1, 6'h12, 0, 0, 0, 0, 0); chk("af_rd_off", Main_rd, 0);
    nx(1, 6'h00, 0, 0, 0, 0, 0); chk("af_push", VC0_wr, 1); chk("af_data", VC_data, 6'h12);
    nx(1, 6'h00, 0, 0, 0, 0, 0);
    nx(1, 6'h00, 0, 0, 0, 0, 0); chk("af_idle2", state, 2);

    // init with two words in flight; thresholds only reload inside INIT
    umbral_vc0_in = 4'd3; umbral_vc1_in = 4'd5;
    nx(0, 6'h00, 0, 0, 0, 0, 0); chk("i_th_hold", umbral_vc0, 4);
    nx(0, 6'h00, 0, 0, 0, 0, 0); chk("i_rd0", Main_rd, 1);
    nx(0, 6'h07, 0, 0, 0, 0, 0); chk("i_rd1", Main_rd, 1);
    nx(0, 6'h2A, 1, 0, 0, 0, 0); chk("i_rd_blk", Main_rd, 0);
    chk("i_w0", VC0_wr, 1); chk("i_w0_data", VC_data, 6'h07);
    nx(0, 6'h00, 1, 0, 0, 0, 0); chk("i_w1", VC1_wr, 1); chk("i_w1_data", VC_data, 6'h2A);
    chk("i_wait", state, 3);
    nx(0, 6'h00, 1, 0, 0, 0, 0); chk("i_wait2", state, 3); chk("i_nopush", VC0_wr | VC1_wr, 0);
    nx(0, 6'h00, 1, 0, 0, 0, 0); chk("i_in_init", state, 1); chk("i_init_rd", Main_rd, 0);
    nx(1, 6'h00, 0, 0, 0, 0, 0); chk("i_th0", umbral_vc0, 3); chk("i_th1", umbral_vc1, 5);
    nx(1, 6'h00, 0, 0, 0, 0, 0); chk("i_idle", state, 2);

    // overflow: push 0x01 into a full VC0
    nx(0, 6'h00, 0, 0, 0, 0, 0);
    nx(0, 6'h00, 0, 0, 0, 1, 0); chk("o_rd", Main_rd, 1);
    nx(1, 6'h01, 0, 0, 0, 1, 0);
    nx(1, 6'h01, 0, 0, 0, 1, 0); chk("o_suppress", VC0_wr, 0); chk("o_vc1", VC1_wr, 0);
    nx(0, 6'h00, 0, 0, 0, 0, 0); chk("o_state", state, 4); chk("o_err", error, 1);
    chk("o_rd_blk", Main_rd, 0);
    nx(0, 6'h00, 1, 0, 0, 0, 0); chk("o_sticky", state, 4); chk("o_rd_blk2", Main_rd, 0);
    chk("o_nopush", VC0_wr | VC1_wr, 0);

    // reset mid-stream, one cycle after a pop
    @(negedge clk); reset = 1'b1; #1;
    chk("m_rst_err", error, 0);
    @(negedge clk); reset = 1'b0; init = 1'b1; Main_empty = 1'b1; #1;
    nx(1, 6'h00, 1, 0, 0, 0, 0); chk("m_init", state, 1);
    nx(1, 6'h00, 0, 0, 0, 0, 0);
    nx(0, 6'h00, 0, 0, 0, 0, 0); chk("m_idle", state, 2);
    nx(0, 6'h00, 0, 0, 0, 0, 0); chk("m_rd", Main_rd, 1);
    @(negedge clk); Main_data = 6'h20; reset = 1'b1; #1;
    chk("m_rst_rd", Main_rd, 0); chk("m_rst_wr", VC0_wr | VC1_wr, 0);
    chk("m_rst_state", state, 0); chk("m_rst_data", VC_data, 0);
    nx(0, 6'h20, 0, 0, 0, 0, 0); chk("m_rst_wr2", VC0_wr | VC1_wr, 0);
    @(negedge clk); reset = 1'b0; Main_empty = 1'b1; #1;
    chk("m_rel_state", state, 0); chk("m_rel_wr", VC0_wr | VC1_wr, 0);
    nx(1, 6'h00, 0, 0, 0, 0, 0); chk("m_rel_init", state, 1); chk("m_drop", VC1_wr | VC0_wr, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/vc_push_ctrl.md
Name: vc_push_ctrl

Overview:
- Write-side controller for the VC0/VC1 virtual-channel FIFOs.
- Pops words from the Main input FIFO, classifies each word by its VC-select bit, and pushes it into VC0 or VC1.
- Throttles on the VC almost-full flags, latches the VC almost-full thresholds during INIT, and reports IDLE/ERROR status.
- Sits upstream of the VC pop arbiter that drains VC0/VC1 into D0/D1.

Parameters:
- DATA_WIDTH, 6, word width of Main and VC FIFO data.
- VC_SEL_BIT, 5, bit index selecting VC1 (1) or VC0 (0).
- TH_WIDTH, 4, width of the almost-full threshold fields.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- init  in  1  request to enter INIT and reload thresholds.
- umbral_vc0_in  in  TH_WIDTH  VC0 almost-full threshold, sampled in INIT.
- umbral_vc1_in  in  TH_WIDTH  VC1 almost-full threshold, sampled in INIT.
- Main_empty  in  1  Main FIFO empty.
- Main_data  in  DATA_WIDTH  Main FIFO read data; valid the cycle after Main_rd.
- VC0_almost_full  in  1  VC0 almost-full flag.
- VC1_almost_full  in  1  VC1 almost-full flag.
- VC0_full  in  1  VC0 full flag.
- VC1_full  in  1  VC1 full flag.
- Main_rd  out  1  Main FIFO pop (combinational).
- VC0_wr  out  1  VC0 push (registered).
- VC1_wr  out  1  VC1 push (registered).
- VC_data  out  DATA_WIDTH  push data to both VCs (registered).
- umbral_vc0  out  TH_WIDTH  latched VC0 threshold.
- umbral_vc1  out  TH_WIDTH  latched VC1 threshold.
- state  out  3  current FSM state encoding.
- idle  out  1  high in IDLE.
- error  out  1  high in ERROR.

Behaviour:
- Reset is asynchronous: while reset=1, all outputs are 0, the thresholds are 0, rd_pend=0, and state=RESET.
- States (encoding):
  - RESET=0: one cycle after reset deasserts, go to INIT.
  - INIT=1: thresholds load from the *_in ports every cycle in INIT. Go to IDLE when init=0. No pops occur in INIT.
  - IDLE=2: go to ACTIVE when Main_empty=0. Go to INIT when init=1.
  - ACTIVE=3: go to IDLE when Main_empty=1 and rd_pend=0 and no push is being issued. Go to INIT when init=1, but only once the pipeline is empty; otherwise wait.
  - ERROR=4: sticky; only reset exits. All pops and pushes are 0.
- Pop rule:
  - Main_rd = (state==ACTIVE) & !Main_empty & !VC0_almost_full & !VC1_almost_full & !init.
  - Both VCs are checked because the destination is unknown until the word is read.
  - The almost-full thresholds must leave at least 2 free entries to cover the in-flight words.
- Pipeline, total latency pop-to-push 2 cycles:
  - Cycle N: Main_rd=1, and rd_pend is set for cycle N+1.
  - Cycle N+1: Main_data is valid. At the edge ending N+1, VC_data<=Main_data, VC1_wr<=Main_data[VC_SEL_BIT], VC0_wr<=!Main_data[VC_SEL_BIT].
  - Cycle N+2: exactly one push is high.
- Back-to-back pops sustain 1 word/cycle.
- When no word is pending, VCx_wr is 0 and VC_data holds its last value.
- Overflow:
  - Condition: a registered push targets a VC whose full flag is high in the push cycle.
  - Action: the next state is ERROR, and that cycle's push is suppressed combinationally.
  - The other VC is unaffected in that cycle.
- Simultaneous events:
  - init=1 and overflow in the same cycle: ERROR wins.
  - init asserted with words in flight: the in-flight words complete, then the FSM enters INIT.
- Reset mid-operation: in-flight words are dropped and all flags clear immediately.

Decomposition:
- Shared package (vc_pkg): state encodings (ST_RESET..ST_ERROR), DATA_WIDTH, VC_SEL_BIT, TH_WIDTH defaults, and the constant MIN_AF_SLACK=2.
- One natural sub-module: vc_route_stage. It is the registered demux from Main_data and rd_pend to VC0_wr/VC1_wr/VC_data with overflow detect.
- The FSM and pop logic stay in the top-level block.

Test Plan:
- Reset, then init=1 with umbral_vc0_in=4 and umbral_vc1_in=6 for 2 cycles, then init=0 -> umbral_vc0=4, umbral_vc1=6, state RESET→INIT→IDLE, idle=1.
- Main holds 0x25, 0x05, 0x3F (bit5=1,0,1), no almost-full -> Main_rd for 3 cycles; 2 cycles later VC1_wr,VC0_wr,VC1_wr with VC_data 0x25,0x05,0x3F; then Main_empty returns the FSM to IDLE.
- VC0_almost_full=1 while Main is non-empty -> Main_rd=0, no pushes; deassert the flag -> pops resume the next cycle.
- Push 0x01 to VC0 while VC0_full=1 -> VC0_wr suppressed, state=ERROR, error=1; later Main activity produces no pops until reset.
- init=1 with 2 words in flight -> both pushes complete, then state=INIT and Main_rd=0 while init=1.
- reset=1 mid-stream, one cycle after a pop -> VC0_wr/VC1_wr/Main_rd drop to 0 immediately, no push of the pending word.
